// File: rtl/shift_pipe_if.sv
// Request/response bundle between an execute-stage issuer and shift_pipe.
interface shift_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned SH_W = $clog2(XLEN);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        op_i;
    logic              word_i;
    logic [XLEN-1:0]   rs1_data_i;
    logic [SH_W-1:0]   shamt_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   data_o;
    logic [TAG_W-1:0]  tag_o;
    logic              illegal_o;

    // Issuer side: offers operations, consumes results.
    modport master (
        output in_valid_i, op_i, word_i, rs1_data_i, shamt_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, tag_o, illegal_o
    );

    // Shifter side.
    modport slave (
        input  in_valid_i, op_i, word_i, rs1_data_i, shamt_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, tag_o, illegal_o
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with elastic valid/ready stages, flush and
// a pass-through writeback tag. Log-shifter layers are spread over the stages.
module shift_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    shift_pipe_if.slave  bus
);
    localparam int unsigned SH_W = $clog2(XLEN);
    localparam int unsigned NL   = SH_W;
    localparam int unsigned NS   = PIPE_STAGES;

    // Stage owning layer j (layer 0 is the largest amount); earlier stages
    // take the extra layer when the split is uneven.
    function automatic int unsigned stage_of(input int unsigned j);
        int unsigned base;
        int unsigned rem;
        int unsigned big;
        base = NL / NS;
        rem  = NL % NS;
        big  = rem * (base + 1);
        if (j < big) return j / (base + 1);
        return rem + (j - big) / base;
    endfunction

    // One log-shifter layer by a fixed power-of-two amount.
    function automatic logic [XLEN-1:0] shift_layer(
        input logic [XLEN-1:0] x,
        input int unsigned     amt,
        input logic            left,
        input logic            rot,
        input logic            arith
    );
        logic [XLEN-1:0] res;
        res = x >> amt;
        if (left) begin
            res = rot ? ((x << amt) | (x >> (XLEN - amt))) : (x << amt);
        end else if (rot) begin
            res = (x >> amt) | (x << (XLEN - amt));
        end else if (arith) begin
            res = $unsigned($signed(x) >>> amt);
        end
        return res;
    endfunction

    logic [NS-1:0]    v_q;
    logic [XLEN-1:0]  dat_q [NS];
    logic [SH_W-1:0]  sh_q  [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic [NS-1:0]    left_q, rot_q, arith_q, word_q, ill_q;

    logic [XLEN-1:0]  dat_d [NS];
    logic [SH_W-1:0]  sh_d  [NS];
    logic [TAG_W-1:0] tag_d [NS];
    logic [NS-1:0]    left_d, rot_d, arith_d, word_d, ill_d;

    logic [NS-1:0]    ld_c, adv_c, in_v_c;

    logic             word_c, ill_c, left_c, rot_c, arith_c;
    logic [XLEN-1:0]  opnd_c;
    logic [SH_W-1:0]  sh_c;

    // Decode and word-mode operand/amount preparation.
    always_comb begin
        word_c  = (XLEN == 64) && bus.word_i;
        left_c  = 1'b0;
        rot_c   = 1'b0;
        arith_c = 1'b0;
        ill_c   = 1'b0;
        case (bus.op_i)
            3'b000: left_c = 1'b1;
            3'b001: begin end
            3'b010: arith_c = 1'b1;
            3'b011: begin left_c = 1'b1; rot_c = 1'b1; ill_c = word_c; end
            3'b100: begin rot_c = 1'b1; ill_c = word_c; end
            default: ill_c = 1'b1;
        endcase
        opnd_c = bus.rs1_data_i;
        sh_c   = bus.shamt_i;
        // Word ops run in the full-width datapath: SRAW sees a sign-extended
        // operand so arithmetic fill lands in bit 31; low 32 bits are kept later.
        if (word_c) begin
            opnd_c = arith_c ? XLEN'($signed(bus.rs1_data_i[31:0])) : XLEN'(bus.rs1_data_i[31:0]);
            sh_c   = SH_W'(bus.shamt_i[4:0]);
        end
    end

    // Valid chain: a stage loads when empty or draining; bubbles collapse.
    always_comb begin
        logic nxt_ld;
        ld_c   = '0;
        adv_c  = '0;
        in_v_c = '0;
        nxt_ld = bus.out_ready_i;
        for (int k = int'(NS) - 1; k >= 0; k--) begin
            adv_c[k] = v_q[k] & nxt_ld;
            ld_c[k]  = ~v_q[k] | adv_c[k];
            nxt_ld   = ld_c[k];
        end
        in_v_c[0] = bus.in_valid_i;
        for (int unsigned k = 1; k < NS; k++) begin
            in_v_c[k] = v_q[k-1];
        end
    end

    // Per-stage shift layers; the last stage also does word sign extension.
    always_comb begin
        logic [XLEN-1:0]  d;
        logic [SH_W-1:0]  s;
        logic [TAG_W-1:0] t;
        logic             l, r, a, w, il;
        left_d  = '0;
        rot_d   = '0;
        arith_d = '0;
        word_d  = '0;
        ill_d   = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (k == 0) begin
                d = opnd_c;  s = sh_c;  t = bus.tag_i;
                l = left_c;  r = rot_c; a = arith_c; w = word_c; il = ill_c;
            end else begin
                d = dat_q[k-1];  s = sh_q[k-1];  t = tag_q[k-1];
                l = left_q[k-1]; r = rot_q[k-1]; a = arith_q[k-1];
                w = word_q[k-1]; il = ill_q[k-1];
            end
            sh_d[k]    = s;
            tag_d[k]   = t;
            left_d[k]  = l;
            rot_d[k]   = r;
            arith_d[k] = a;
            word_d[k]  = w;
            ill_d[k]   = il;
            for (int unsigned j = 0; j < NL; j++) begin
                if (stage_of(j) == k && s[NL-1-j]) begin
                    d = shift_layer(d, 32'd1 << (NL - 1 - j), l, r, a);
                end
            end
            if (k == NS - 1) begin
                if (il) begin
                    d = '0;
                end else if (w) begin
                    d = XLEN'($signed(d[31:0]));
                end
            end
            dat_d[k] = d;
        end
    end

    // Stage registers; flush wins over both accept and advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q     <= '0;
            left_q  <= '0;
            rot_q   <= '0;
            arith_q <= '0;
            word_q  <= '0;
            ill_q   <= '0;
            for (int unsigned k = 0; k < NS; k++) begin
                dat_q[k] <= '0;
                sh_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NS; k++) begin
                if (flush_i) begin
                    v_q[k] <= 1'b0;
                end else if (ld_c[k]) begin
                    v_q[k] <= in_v_c[k];
                end
                if (!flush_i && ld_c[k] && in_v_c[k]) begin
                    dat_q[k]   <= dat_d[k];
                    sh_q[k]    <= sh_d[k];
                    tag_q[k]   <= tag_d[k];
                    left_q[k]  <= left_d[k];
                    rot_q[k]   <= rot_d[k];
                    arith_q[k] <= arith_d[k];
                    word_q[k]  <= word_d[k];
                    ill_q[k]   <= ill_d[k];
                end
            end
        end
    end

    assign bus.in_ready_o  = ld_c[0];
    assign bus.out_valid_o = v_q[NS-1];
    assign bus.data_o      = dat_q[NS-1];
    assign bus.tag_o       = tag_q[NS-1];
    assign bus.illegal_o   = ill_q[NS-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 32-bit/2-stage, 64-bit/3-stage and
// 32-bit/5-stage instances with hand-computed expected results.
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic f32, f64, f5;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    shift_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    shift_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();
    shift_pipe_if #(.XLEN(32), .TAG_W(5)) b5  ();

    shift_pipe #(.XLEN(32), .PIPE_STAGES(2), .TAG_W(5)) u32 (
        .clk(clk), .reset_n(rst_n), .flush_i(f32), .bus(b32.slave));
    shift_pipe #(.XLEN(64), .PIPE_STAGES(3), .TAG_W(5)) u64 (
        .clk(clk), .reset_n(rst_n), .flush_i(f64), .bus(b64.slave));
    shift_pipe #(.XLEN(32), .PIPE_STAGES(5), .TAG_W(5)) u5 (
        .clk(clk), .reset_n(rst_n), .flush_i(f5), .bus(b5.slave));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One op through the 32-bit/2-stage instance, checking latency and result.
    task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] rs1,
                         input logic [4:0] sh, input logic [4:0] tg,
                         input logic [31:0] exp, input logic exp_ill);
        int lat;
        b32.out_ready_i = 1'b1;
        b32.in_valid_i  = 1'b1;
        b32.op_i        = op;
        b32.rs1_data_i  = rs1;
        b32.shamt_i     = sh;
        b32.tag_i       = tg;
        #1;
        check_eq({tag, "_rdy"}, 64'(b32.in_ready_o), 64'd1);
        @(posedge clk); #1;
        b32.in_valid_i = 1'b0;
        lat = 1;
        while (!b32.out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd2);
        check_eq({tag, "_data"}, 64'(b32.data_o), 64'(exp));
        check_eq({tag, "_tag"}, 64'(b32.tag_o), 64'(tg));
        check_eq({tag, "_ill"}, 64'(b32.illegal_o), 64'(exp_ill));
        @(posedge clk); #1;
    endtask

    // One op through the 64-bit/3-stage instance.
    task automatic run64(input string tag, input logic [2:0] op, input logic wd,
                         input logic [63:0] rs1, input logic [5:0] sh, input logic [4:0] tg,
                         input logic [63:0] exp, input logic exp_ill);
        int lat;
        b64.out_ready_i = 1'b1;
        b64.in_valid_i  = 1'b1;
        b64.op_i        = op;
        b64.word_i      = wd;
        b64.rs1_data_i  = rs1;
        b64.shamt_i     = sh;
        b64.tag_i       = tg;
        @(posedge clk); #1;
        b64.in_valid_i = 1'b0;
        lat = 1;
        while (!b64.out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd3);
        check_eq({tag, "_data"}, b64.data_o, exp);
        check_eq({tag, "_tag"}, 64'(b64.tag_o), 64'(tg));
        check_eq({tag, "_ill"}, 64'(b64.illegal_o), 64'(exp_ill));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcv, cyc, n, g, lat;
        logic stalled;
        logic [31:0] held_d;
        logic [4:0]  held_t;

        rst_n = 1'b0;
        f32 = 1'b0; f64 = 1'b0; f5 = 1'b0;
        b32.in_valid_i = 1'b0; b32.op_i = '0; b32.word_i = 1'b0; b32.rs1_data_i = '0;
        b32.shamt_i = '0; b32.tag_i = '0; b32.out_ready_i = 1'b1;
        b64.in_valid_i = 1'b0; b64.op_i = '0; b64.word_i = 1'b0; b64.rs1_data_i = '0;
        b64.shamt_i = '0; b64.tag_i = '0; b64.out_ready_i = 1'b1;
        b5.in_valid_i = 1'b0; b5.op_i = '0; b5.word_i = 1'b0; b5.rs1_data_i = '0;
        b5.shamt_i = '0; b5.tag_i = '0; b5.out_ready_i = 1'b1;

        #2;
        check_eq("rst_valid32", 64'(b32.out_valid_o), 64'd0);
        check_eq("rst_ready32", 64'(b32.in_ready_o), 64'd1);
        check_eq("rst_data32", 64'(b32.data_o), 64'd0);
        check_eq("rst_tag32", 64'(b32.tag_o), 64'd0);
        check_eq("rst_ill32", 64'(b32.illegal_o), 64'd0);
        check_eq("rst_valid64", 64'(b64.out_valid_o), 64'd0);
        check_eq("rst_data64", b64.data_o, 64'd0);
        check_eq("rst_ready5", 64'(b5.in_ready_o), 64'd1);
        #21;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit, 2 stages
        run32("sra",   3'b010, 32'h8000_00F0, 5'd4,  5'd3, 32'hF800_000F, 1'b0);
        run32("ror",   3'b100, 32'h0000_0001, 5'd1,  5'd4, 32'h8000_0000, 1'b0);
        run32("rol",   3'b011, 32'h8000_0001, 5'd1,  5'd5, 32'h0000_0003, 1'b0);
        run32("srl31", 3'b001, 32'h8000_0000, 5'd31, 5'd6, 32'h0000_0001, 1'b0);
        run32("sra0",  3'b010, 32'h8000_0000, 5'd0,  5'd7, 32'h8000_0000, 1'b0);
        run32("ill32", 3'b101, 32'h1234_5678, 5'd2,  5'd8, 32'h0000_0000, 1'b1);

        // 64-bit, 3 stages, word and full-width ops
        run64("sllw",   3'b000, 1'b1, 64'h0000_0000_4000_0001, 6'd1,  5'd1, 64'hFFFF_FFFF_8000_0002, 1'b0);
        run64("sraw",   3'b010, 1'b1, 64'hFFFF_FFFF_0000_0080, 6'd3,  5'd2, 64'h0000_0000_0000_0010, 1'b0);
        run64("sraw_b5",3'b010, 1'b1, 64'h0000_0000_8000_0000, 6'h21, 5'd3, 64'hFFFF_FFFF_C000_0000, 1'b0);
        run64("srlw0",  3'b001, 1'b1, 64'h1234_5678_8000_0000, 6'd0,  5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run64("srlw",   3'b001, 1'b1, 64'h0000_0000_8000_0000, 6'd1,  5'd5, 64'h0000_0000_4000_0000, 1'b0);
        run64("sra64",  3'b010, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run64("ror64",  3'b100, 1'b0, 64'h0000_0000_0000_0001, 6'd4,  5'd7, 64'h1000_0000_0000_0000, 1'b0);
        run64("rol64",  3'b011, 1'b0, 64'h8000_0000_0000_0001, 6'd4,  5'd8, 64'h0000_0000_0000_0018, 1'b0);
        run64("ill111", 3'b111, 1'b0, 64'h0000_0000_0000_0005, 6'd1,  5'd9, 64'h0, 1'b1);
        run64("rolw",   3'b011, 1'b1, 64'h0000_0000_0000_0005, 6'd1,  5'd10, 64'h0, 1'b1);

        // 5 stages, back-to-back SLL with toggling out_ready
        sent = 0; rcv = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_t = '0;
        while (rcv < 8 && cyc < 200) begin
            if (stalled) begin
                check_eq("stall_valid", 64'(b5.out_valid_o), 64'd1);
                check_eq("stall_data", 64'(b5.data_o), 64'(held_d));
                check_eq("stall_tag", 64'(b5.tag_o), 64'(held_t));
            end
            b5.out_ready_i = (cyc % 2 == 0);
            b5.in_valid_i  = (sent < 8);
            b5.op_i        = 3'b000;
            b5.rs1_data_i  = 32'd1;
            b5.shamt_i     = 5'(sent);
            b5.tag_i       = 5'(sent);
            #1;
            if (b5.in_valid_i && b5.in_ready_o) sent++;
            stalled = 1'b0;
            if (b5.out_valid_o) begin
                if (b5.out_ready_i) begin
                    check_eq("b2b_data", 64'(b5.data_o), 64'(32'd1 << rcv));
                    check_eq("b2b_tag", 64'(b5.tag_o), 64'(rcv));
                    rcv++;
                end else begin
                    stalled = 1'b1;
                    held_d  = b5.data_o;
                    held_t  = b5.tag_o;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        b5.in_valid_i = 1'b0;
        check_eq("b2b_count", 64'(rcv), 64'd8);
        check_eq("b2b_sent", 64'(sent), 64'd8);
        check_eq("b2b_nodup", 64'(b5.out_valid_o), 64'd0);

        // Fill 5-stage pipe under backpressure, then flush with an input offered
        b5.out_ready_i = 1'b0;
        n = 0; g = 0;
        while (n < 5 && g < 20) begin
            b5.in_valid_i = 1'b1;
            b5.rs1_data_i = 32'd1;
            b5.shamt_i    = 5'd1;
            b5.tag_i      = 5'(10 + n);
            #1;
            if (b5.in_ready_o) n++;
            @(posedge clk); #1;
            g++;
        end
        b5.tag_i = 5'd20;
        #1;
        check_eq("full_rdy", 64'(b5.in_ready_o), 64'd0);
        check_eq("full_head", 64'(b5.tag_o), 64'd10);
        f5 = 1'b1;
        b5.out_ready_i = 1'b1;
        #1;
        check_eq("flush_in_rdy", 64'(b5.in_ready_o), 64'd1);
        @(posedge clk); #1;
        f5 = 1'b0;
        b5.in_valid_i = 1'b0;
        check_eq("flush_valid", 64'(b5.out_valid_o), 64'd0);
        check_eq("flush_rdy", 64'(b5.in_ready_o), 64'd1);
        b5.in_valid_i = 1'b1;
        b5.rs1_data_i = 32'd3;
        b5.shamt_i    = 5'd2;
        b5.tag_i      = 5'd21;
        @(posedge clk); #1;
        b5.in_valid_i = 1'b0;
        lat = 1;
        while (!b5.out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("post_flush_lat", 64'(lat), 64'd5);
        check_eq("post_flush_tag", 64'(b5.tag_o), 64'd21);
        check_eq("post_flush_data", 64'(b5.data_o), 64'd12);
        @(posedge clk); #1;

        // Async reset while a result is held at the output
        b32.out_ready_i = 1'b0;
        b32.in_valid_i  = 1'b1;
        b32.op_i        = 3'b000;
        b32.rs1_data_i  = 32'h55;
        b32.shamt_i     = 5'd1;
        b32.tag_i       = 5'd7;
        @(posedge clk); #1;
        b32.in_valid_i = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_data", 64'(b32.data_o), 64'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(b32.out_valid_o), 64'd0);
        check_eq("mid_rst_data", 64'(b32.data_o), 64'd0);
        check_eq("mid_rst_tag", 64'(b32.tag_o), 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_rdy", 64'(b32.in_ready_o), 64'd1);
        check_eq("post_rst_valid", 64'(b32.out_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
